// File: rtl/iq_symbol_mapper.sv
// QPSK symbol mapper: splits payload bytes into dibits, maps them to offset-binary I/Q
// and midscale-pads to SPS samples per symbol. Optional macro: IQ_SYMBOL_MAPPER_PRBS_EN.
module iq_symbol_mapper #(
    parameter int SPS = 4,
    parameter int AMP = 90,
    parameter int MID = 128
) (
    input  logic       i_clk_x16,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_data_ready,
    input  logic       i_fir_ready,
    output logic [7:0] o_I,
    output logic [7:0] o_Q,
    output logic       o_sym_strobe,
    output logic       o_underflow
);

    localparam int PW = (SPS > 2) ? $clog2(SPS) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(SPS - 1);

    function automatic logic [7:0] sat_rail(input int base, input int delta);
        int sum;
        sum = base + delta;
        if (sum < 0) begin
            return 8'd0;
        end else if (sum > 255) begin
            return 8'd255;
        end else begin
            return 8'(sum);
        end
    endfunction

    localparam logic [7:0] RAIL_POS = sat_rail(MID, AMP);
    localparam logic [7:0] RAIL_NEG = sat_rail(MID, -AMP);
    localparam logic [7:0] RAIL_MID = sat_rail(MID, 0);

    // A zero bit maps above midscale, a one bit below.
    function automatic logic [7:0] map_bit(input logic b);
        return b ? RAIL_NEG : RAIL_POS;
    endfunction

    typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_t;

    buf_state_t    buf_state_r, buf_state_s;
    logic [7:0]    byte_r, byte_s;
    logic [1:0]    idx_r, idx_s;
    logic [PW-1:0] phase_r, phase_s;
    logic [7:0]    i_r, i_s;
    logic [7:0]    q_r, q_s;
    logic          strobe_r, strobe_s;
    logic          underflow_r, underflow_s;
    logic [1:0]    dibit_s;
    logic          tick_s, slot_s, ready_s, accept_s;
`ifdef IQ_SYMBOL_MAPPER_PRBS_EN
    logic [8:0]    prbs_r, prbs_s;
`endif

    assign tick_s   = i_fir_ready & i_en;
    assign slot_s   = tick_s & (phase_r == {PW{1'b0}});
    // Ready also covers the last dibit being consumed this cycle, so bytes can stream gap-free.
    assign ready_s  = ~i_rst & ((buf_state_r == BUF_EMPTY) | ((idx_r == 2'd3) & slot_s));
    assign accept_s = i_valid & ready_s & i_en;

    assign o_data_ready = ready_s;
    assign o_I          = i_r;
    assign o_Q          = q_r;
    assign o_sym_strobe = strobe_r;
    assign o_underflow  = underflow_r;

    // Dibit selection, MSB pair first.
    always_comb begin
        case (idx_r)
            2'd0:    dibit_s = byte_r[7:6];
            2'd1:    dibit_s = byte_r[5:4];
            2'd2:    dibit_s = byte_r[3:2];
            2'd3:    dibit_s = byte_r[1:0];
            default: dibit_s = 2'b00;
        endcase
    end

    // Next-state for buffer, phase and output samples.
    always_comb begin
        buf_state_s = buf_state_r;
        byte_s      = byte_r;
        idx_s       = idx_r;
        phase_s     = phase_r;
        i_s         = i_r;
        q_s         = q_r;
        strobe_s    = 1'b0;
        underflow_s = underflow_r;
`ifdef IQ_SYMBOL_MAPPER_PRBS_EN
        prbs_s      = prbs_r;
`endif

        if (tick_s) begin
            if (phase_r == PHASE_LAST) begin
                phase_s = {PW{1'b0}};
            end else begin
                phase_s = phase_r + PW'(1);
            end
        end else begin
            phase_s = phase_r;
        end

        if (slot_s) begin
            if (buf_state_r == BUF_FULL) begin
                i_s      = map_bit(dibit_s[1]);
                q_s      = map_bit(dibit_s[0]);
                strobe_s = 1'b1;
                idx_s    = idx_r + 2'd1;
                if (idx_r == 2'd3) begin
                    buf_state_s = BUF_EMPTY;
                end else begin
                    buf_state_s = BUF_FULL;
                end
            end else begin
                underflow_s = 1'b1;
`ifdef IQ_SYMBOL_MAPPER_PRBS_EN
                // Two PRBS9 (x^9+x^5+1) steps per slot; first bit out drives I.
                i_s      = map_bit(prbs_r[8]);
                q_s      = map_bit(prbs_r[7]);
                strobe_s = 1'b1;
                prbs_s   = {prbs_r[6:0], prbs_r[8] ^ prbs_r[4], prbs_r[7] ^ prbs_r[3]};
`else
                i_s      = RAIL_MID;
                q_s      = RAIL_MID;
`endif
            end
        end else if (tick_s) begin
            i_s = RAIL_MID;
            q_s = RAIL_MID;
        end else begin
            i_s = i_r;
            q_s = q_r;
        end

        // A byte landing on an empty slot is kept for the next slot, not used for this one.
        if (accept_s) begin
            buf_state_s = BUF_FULL;
            byte_s      = i_data;
            idx_s       = 2'd0;
        end else begin
            byte_s = byte_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk_x16) begin
        if (i_rst) begin
            buf_state_r <= BUF_EMPTY;
            byte_r      <= 8'd0;
            idx_r       <= 2'd0;
            phase_r     <= {PW{1'b0}};
            i_r         <= RAIL_MID;
            q_r         <= RAIL_MID;
            strobe_r    <= 1'b0;
            underflow_r <= 1'b0;
`ifdef IQ_SYMBOL_MAPPER_PRBS_EN
            prbs_r      <= 9'h1FF;
`endif
        end else begin
            buf_state_r <= buf_state_s;
            byte_r      <= byte_s;
            idx_r       <= idx_s;
            phase_r     <= phase_s;
            i_r         <= i_s;
            q_r         <= q_s;
            strobe_r    <= strobe_s;
            underflow_r <= underflow_s;
`ifdef IQ_SYMBOL_MAPPER_PRBS_EN
            prbs_r      <= prbs_s;
`endif
        end
    end

endmodule

// File: tb/tb_iq_symbol_mapper.sv
// Scoreboard bench for iq_symbol_mapper: stimulus pushes expected samples per tick,
// a monitor pops and compares after each tick edge.
module tb_iq_symbol_mapper;

    logic       i_clk_x16 = 1'b0;
    logic       i_rst, i_en, i_valid, i_fir_ready;
    logic [7:0] i_data;
    logic       o_data_ready, o_sym_strobe, o_underflow;
    logic [7:0] o_I, o_Q;

    always #5 i_clk_x16 = ~i_clk_x16;

    iq_symbol_mapper dut (
        .i_clk_x16   (i_clk_x16),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_data_ready(o_data_ready),
        .i_fir_ready (i_fir_ready),
        .o_I         (o_I),
        .o_Q         (o_Q),
        .o_sym_strobe(o_sym_strobe),
        .o_underflow (o_underflow)
    );

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] q;
        logic       s;
    } exp_t;

    localparam logic [7:0] HI  = 8'hDA;
    localparam logic [7:0] LO  = 8'h26;
    localparam logic [7:0] PAD = 8'h80;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_tick = 1'b0;
    logic mon_on   = 1'b0;
    logic rst_drv  = 1'b1;
    logic en_drv   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge i_clk_x16) mon_tick <= i_fir_ready & i_en & ~i_rst;

    // Monitor: every tick edge must match the oldest expectation.
    always @(negedge i_clk_x16) begin
        exp_t e;
        if (mon_on) begin
            if (mon_tick) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tick: got I=%0h Q=%0h expected no output", o_I, o_Q);
                end else begin
                    e = exp_q.pop_front();
                    chk("tick_I", {24'd0, o_I}, {24'd0, e.i});
                    chk("tick_Q", {24'd0, o_Q}, {24'd0, e.q});
                    chk("tick_strobe", {31'd0, o_sym_strobe}, {31'd0, e.s});
                end
            end else begin
                chk("idle_strobe", {31'd0, o_sym_strobe}, 32'd0);
            end
        end
    end

    task automatic cyc(input logic fir, input logic vld, input logic [7:0] d,
                       input logic [7:0] ei, input logic [7:0] eq, input logic es,
                       output logic rdy, output logic acc);
        exp_t e;
        @(negedge i_clk_x16);
        i_rst       = rst_drv;
        i_en        = en_drv;
        i_fir_ready = fir;
        i_valid     = vld;
        i_data      = d;
        if (fir && en_drv && !rst_drv) begin
            e.i = ei;
            e.q = eq;
            e.s = es;
            exp_q.push_back(e);
        end
        #1;
        rdy = o_data_ready;
        acc = rdy & vld & en_drv;
        @(posedge i_clk_x16);
        #2;
    endtask

    task automatic tick_pad(input int t, input logic [7:0] si, input logic [7:0] sq, input logic ss);
        logic rdy, acc;
        if (t % 4 == 0) cyc(1'b1, 1'b0, 8'h00, si, sq, ss, rdy, acc);
        else            cyc(1'b1, 1'b0, 8'h00, PAD, PAD, 1'b0, rdy, acc);
        repeat (2) cyc(1'b0, 1'b0, 8'h00, PAD, PAD, 1'b0, rdy, acc);
    endtask

    initial begin
        logic       rdy, acc, vld;
        int         got;
        logic [7:0] map_i [4];
        logic [7:0] map_q [4];
        map_i = '{HI, HI, LO, LO};
        map_q = '{HI, LO, HI, LO};
        i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_fir_ready = 1'b0; i_data = 8'h00;

        // Reset
        rst_drv = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 8'h00, PAD, PAD, 1'b0, rdy, acc);
        chk("rst_ready", {31'd0, rdy}, 32'd0);
        chk("rst_I", {24'd0, o_I}, 32'h80);
        chk("rst_Q", {24'd0, o_Q}, 32'h80);
        chk("rst_underflow", {31'd0, o_underflow}, 32'd0);
        mon_on  = 1'b1;
        rst_drv = 1'b0;

        // Mapping of 0x1B
        cyc(1'b0, 1'b1, 8'h1B, PAD, PAD, 1'b0, rdy, acc);
        chk("ready_after_reset", {31'd0, rdy}, 32'd1);
        chk("accept_1b", {31'd0, acc}, 32'd1);
        for (int t = 0; t < 16; t++) tick_pad(t, map_i[t/4], map_q[t/4], 1'b1);
        chk("map_underflow", {31'd0, o_underflow}, 32'd0);

        // Back-to-back 0xFF then 0x00, with an enable-gated gap after the last symbol
        cyc(1'b0, 1'b1, 8'hFF, PAD, PAD, 1'b0, rdy, acc);
        chk("accept_ff", {31'd0, acc}, 32'd1);
        got = -1;
        for (int t = 0; t < 32; t++) begin
            if (t == 29) begin
                en_drv = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    cyc(1'b1, 1'b1, 8'h00, PAD, PAD, 1'b0, rdy, acc);
                    chk("gated_I", {24'd0, o_I}, {24'd0, HI});
                    chk("gated_Q", {24'd0, o_Q}, {24'd0, HI});
                end
                en_drv = 1'b1;
            end
            vld = (got < 0);
            if (t % 4 == 0) begin
                if (t < 16) cyc(1'b1, vld, 8'h00, LO, LO, 1'b1, rdy, acc);
                else        cyc(1'b1, vld, 8'h00, HI, HI, 1'b1, rdy, acc);
            end else begin
                cyc(1'b1, vld, 8'h00, PAD, PAD, 1'b0, rdy, acc);
            end
            if (acc) got = t;
            for (int k = 0; k < 2; k++) begin
                vld = (got < 0);
                cyc(1'b0, vld, 8'h00, PAD, PAD, 1'b0, rdy, acc);
                if (acc) got = 100;
            end
        end
        chk("b2b_accept_tick", got, 32'd12);
        chk("b2b_underflow", {31'd0, o_underflow}, 32'd0);

        // Underflow: two empty symbol slots
        for (int t = 0; t < 8; t++) begin
`ifdef IQ_SYMBOL_MAPPER_PRBS_EN
            tick_pad(t, LO, LO, 1'b1);
`else
            tick_pad(t, PAD, PAD, 1'b0);
`endif
            if (t == 0) chk("underflow_set", {31'd0, o_underflow}, 32'd1);
        end
        chk("underflow_sticky", {31'd0, o_underflow}, 32'd1);

        // Mid-operation reset after two dibits of 0x6C
        cyc(1'b0, 1'b1, 8'h6C, PAD, PAD, 1'b0, rdy, acc);
        chk("accept_6c", {31'd0, acc}, 32'd1);
        tick_pad(0, HI, LO, 1'b1);
        tick_pad(1, PAD, PAD, 1'b0);
        tick_pad(2, PAD, PAD, 1'b0);
        tick_pad(3, PAD, PAD, 1'b0);
        tick_pad(4, LO, HI, 1'b1);
        rst_drv = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 8'h00, PAD, PAD, 1'b0, rdy, acc);
        chk("midrst_ready", {31'd0, rdy}, 32'd0);
        chk("midrst_I", {24'd0, o_I}, 32'h80);
        chk("midrst_underflow", {31'd0, o_underflow}, 32'd0);
        rst_drv = 1'b0;
        cyc(1'b0, 1'b1, 8'hE4, PAD, PAD, 1'b0, rdy, acc);
        chk("accept_e4", {31'd0, acc}, 32'd1);
        for (int t = 0; t < 5; t++) begin
            if (t == 0)      tick_pad(t, LO, LO, 1'b1);
            else if (t == 4) tick_pad(t, LO, HI, 1'b1);
            else             tick_pad(t, PAD, PAD, 1'b0);
        end

        repeat (3) cyc(1'b0, 1'b0, 8'h00, PAD, PAD, 1'b0, rdy, acc);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iq_symbol_mapper.md
Name: iq_symbol_mapper

Overview:
- Upstream feeder for the IQ FIR pulse-shaping filter in the DVS2 modem transmit path.
- Accepts payload bytes over a valid/ready handshake and splits each byte into four QPSK dibits, MSB first.
- Maps each dibit to unsigned offset-binary 8-bit I/Q and zero-stuffs (midscale pad) to SPS samples per symbol.
- Presents one new I/Q sample per filter ready pulse, timed so the filter captures it on its load cycle.

Parameters:
- SPS, 4, samples per symbol (2..16); phase 0 carries the symbol, phases 1..SPS-1 carry pad.
- AMP, 90, constellation amplitude about midscale (1..127).
- MID, 128, midscale / pad value for both rails.

Ports:
- i_clk_x16  in  1  filter-rate clock, single clock domain.
- i_rst  in  1  synchronous active-high reset.
- i_en  in  1  global enable; when low no state advances and outputs hold.
- i_data  in  8  payload byte.
- i_valid  in  1  i_data valid.
- o_data_ready  out  1  mapper can accept a byte this cycle.
- i_fir_ready  in  1  one-cycle request pulse from the filter (its ready output).
- o_I  out  8  unsigned I sample to the filter.
- o_Q  out  8  unsigned Q sample to the filter.
- o_sym_strobe  out  1  high for one cycle when o_I/o_Q change to a symbol (phase 0) sample.
- o_underflow  out  1  sticky: a symbol slot found no buffered dibit.

Behaviour:
- Clock is i_clk_x16. Reset is synchronous and active-high (i_rst), with a single clock domain.
- Reset values: o_I=o_Q=MID, o_sym_strobe=0, o_underflow=0, phase=0, buffer empty, dibit index=0. o_data_ready=0 during reset and 1 on the first cycle after it.
- Reset mid-operation discards any buffered byte and partial symbol. The PRBS seed reloads.
- Byte buffer: one 8-bit register, EMPTY/FULL state plus 2-bit dibit index (0..3, dibit0 = bits[7:6]).
- o_data_ready = EMPTY, or FULL with index==3 and a symbol slot this cycle. The second case allows back-to-back bytes without a gap.
- Accept: i_valid & o_data_ready & i_en. The buffer loads with index=0 and becomes FULL.
- Tick: i_fir_ready & i_en.
  - Phase counter advances 0..SPS-1 and wraps on each tick.
  - A tick with phase==0 is a symbol slot.
- Symbol slot with buffer FULL:
  - Dibit b1b0 selects the sample: b1=0 gives I=MID+AMP, b1=1 gives I=MID-AMP; b0 maps Q the same way.
  - Index increments. The buffer goes EMPTY after index 3 unless a new accept happens in the same cycle.
- Symbol slot with buffer EMPTY: underflow. o_I=o_Q=MID and o_underflow sets (sticky until reset).
  - A byte accepted in the same cycle as an EMPTY slot is not used for that slot.
- Non-symbol tick: o_I=o_Q=MID.
- Latency: outputs update at the clock edge that samples i_fir_ready high and hold until the next tick. This makes them stable during the filter's load cycle.
- o_sym_strobe is registered with o_I/o_Q and is high only for a symbol slot that had data.
- If i_fir_ready is asserted while i_en is low, it is ignored and the phase does not advance.
- Arithmetic: MID±AMP is computed at 9 bits and saturated to 0..255. With the defaults it never saturates (0xDA / 0x26).

Optional Feature:
- Macro: IQ_SYMBOL_MAPPER_PRBS_EN.
- Defined: on an underflow slot the mapper emits a symbol from an internal PRBS9 instead of MID/MID.
  - Polynomial x^9+x^5+1, seed 9'h1FF at reset, advances 2 bits per underflow slot; first bit is b1.
  - o_underflow still sets and o_sym_strobe still pulses.
- Undefined: no PRBS logic; underflow emits MID/MID as specified above.

Test Plan:
- Reset: hold i_rst 3 cycles -> o_I=o_Q=0x80, o_underflow=0, o_data_ready=0 during reset and 1 on the next cycle.
- Mapping (SPS=4, AMP=90): send byte 0x1B, pulse i_fir_ready every 16 cycles for 16 ticks -> symbol slots emit (DA,DA),(DA,26),(26,DA),(26,26), each followed by 3 ticks of (80,80). o_sym_strobe pulses 4 times; o_underflow stays 0.
- Back-to-back: offer 0xFF then 0x00 continuously -> the second byte is accepted in the same cycle as the 4th symbol slot of the first. Symbols are 4×(26,26) then 4×(DA,DA) with no underflow.
- Underflow: no input, 2 symbol slots -> (80,80) outputs, o_underflow=1 sticky, o_sym_strobe=0. With IQ_SYMBOL_MAPPER_PRBS_EN the first slot emits (26,26) from seed 1FF.
- Enable gating: i_fir_ready pulses while i_en=0 -> outputs, phase and buffer unchanged; a byte offered is not accepted.
- Mid-operation reset: assert i_rst after 2 of 4 dibits -> buffer empties, phase=0, and the next byte's dibit0 appears on the first symbol slot after reset.
